// File: rtl/lsu_mem_master_if.sv
// Request/response handshake and doubleword data-RAM bus between the MEM stage, lsu_mem_master and the RAM.
// master = the load/store unit; slave = the CPU pipeline plus the RAM side.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wstrb;
  logic [63:0]       mem_wdata;
  logic              mem_ack;
  logic [63:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request per handshake, 1-2 doubleword beats, extended load data in a 1-cycle response.
// Latency 3 cycles aligned / 5 split / 1 illegal with immediate ack; req_ready only in IDLE, each beat held until mem_ack.
module lsu_mem_master #(
  parameter int ADDR_W   = 10,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  lsu_mem_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_GAP,
    S_BEAT1,
    S_DONE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_lo;
  logic [63:0]       r_hi;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [63:0]       r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wstrb;
  logic [63:0]       r_mem_wdata;

  logic              w_idle;
  logic              w_we;
  logic [2:0]        w_f3;
  logic [ADDR_W-1:0] w_addr;
  logic [63:0]       w_wdata;
  logic [3:0]        w_size;
  logic [2:0]        w_off;
  logic              w_cross;
  logic              w_illegal;
  logic [15:0]       w_mask;
  logic [127:0]      w_wide;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_base1;
  logic              w_beat_ack;
  logic [63:0]       w_raw;
  logic [63:0]       w_load;

  logic              w_req_ready_n;
  logic              w_resp_valid_n;
  logic [63:0]       w_resp_rdata_n;
  logic              w_resp_err_n;
  logic              w_mem_req_n;
  logic              w_mem_we_n;
  logic [ADDR_W-1:0] w_mem_addr_n;
  logic [7:0]        w_mem_wstrb_n;
  logic [63:0]       w_mem_wdata_n;

  // In IDLE the beat-0 outputs are registered in the same edge that latches the request.
  assign w_idle  = (r_state == S_IDLE);
  assign w_we    = w_idle ? bus.req_we     : r_we;
  assign w_f3    = w_idle ? bus.req_funct3 : r_f3;
  assign w_addr  = w_idle ? bus.req_addr   : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata  : r_wdata;

  assign w_size    = 4'd1 << w_f3[1:0];
  assign w_off     = w_addr[2:0];
  assign w_cross   = ({1'b0, w_off} + w_size) > 4'd8;
  assign w_illegal = (w_we ? w_f3[2] : (w_f3 == 3'b111)) || (w_cross && !SPLIT_EN);
  assign w_mask    = ((16'h1 << w_size) - 16'h1) << w_off;
  assign w_wide    = {64'b0, w_wdata} << {w_off, 3'b000};
  assign w_base    = {w_addr[ADDR_W-1:3], 3'b000};
  assign w_base1   = w_base + ADDR_W'(8);

  assign w_beat_ack = r_mem_req && bus.mem_ack;

  // Stale hi bytes never survive the shift for a non-crossing load.
  assign w_raw = 64'({r_hi, r_lo} >> {r_addr[2:0], 3'b000});

  always_comb begin
    w_load = w_raw;
    case (r_f3[1:0])
      2'd0:    w_load = r_f3[2] ? {56'b0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
      2'd1:    w_load = r_f3[2] ? {48'b0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      2'd2:    w_load = r_f3[2] ? {32'b0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      default: w_load = w_raw;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = w_illegal ? S_RESP : S_BEAT0;
      S_BEAT0: if (w_beat_ack)    w_next = w_cross ? S_GAP : S_DONE;
      S_GAP:   w_next = S_BEAT1;
      S_BEAT1: if (w_beat_ack)    w_next = S_DONE;
      S_DONE:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready_n  = (w_next == S_IDLE);
    w_resp_valid_n = 1'b0;
    w_resp_rdata_n = 64'b0;
    w_resp_err_n   = 1'b0;
    w_mem_req_n    = 1'b0;
    w_mem_we_n     = 1'b0;
    w_mem_addr_n   = '0;
    w_mem_wstrb_n  = 8'b0;
    w_mem_wdata_n  = 64'b0;
    case (w_next)
      S_BEAT0: begin
        w_mem_req_n   = 1'b1;
        w_mem_we_n    = w_we;
        w_mem_addr_n  = w_base;
        w_mem_wstrb_n = w_we ? w_mask[7:0] : 8'b0;
        w_mem_wdata_n = w_wide[63:0];
      end
      S_BEAT1: begin
        w_mem_req_n   = 1'b1;
        w_mem_we_n    = w_we;
        w_mem_addr_n  = w_base1;
        w_mem_wstrb_n = w_we ? w_mask[15:8] : 8'b0;
        w_mem_wdata_n = w_wide[127:64];
      end
      S_RESP: begin
        w_resp_valid_n = 1'b1;
        // RESP reached straight from IDLE only for a rejected request.
        w_resp_err_n   = (r_state == S_IDLE);
        w_resp_rdata_n = ((r_state == S_DONE) && !r_we) ? w_load : 64'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'b0;
      r_addr       <= '0;
      r_wdata      <= 64'b0;
      r_lo         <= 64'b0;
      r_hi         <= 64'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'b0;
      r_resp_err   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 8'b0;
      r_mem_wdata  <= 64'b0;
    end else begin
      r_state      <= w_next;
      r_req_ready  <= w_req_ready_n;
      r_resp_valid <= w_resp_valid_n;
      r_resp_rdata <= w_resp_rdata_n;
      r_resp_err   <= w_resp_err_n;
      r_mem_req    <= w_mem_req_n;
      r_mem_we     <= w_mem_we_n;
      r_mem_addr   <= w_mem_addr_n;
      r_mem_wstrb  <= w_mem_wstrb_n;
      r_mem_wdata  <= w_mem_wdata_n;
      if (w_idle && bus.req_valid) begin
        r_we    <= bus.req_we;
        r_f3    <= bus.req_funct3;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if ((r_state == S_BEAT0) && w_beat_ack) r_lo <= bus.mem_rdata;
      if ((r_state == S_BEAT1) && w_beat_ack) r_hi <= bus.mem_rdata;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wstrb  = r_mem_wstrb;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: beat and response scoreboards fed at stimulus time, checked as the DUT produces them.
// A second instance with SPLIT_EN=0 covers the crossing-rejection path.
module tb_lsu_mem_master;

  typedef struct packed {
    logic [9:0]  addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } beat_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    vectors = 0;
  int    miscompares = 0;
  int    nbeats = 0;
  int    ack_delay = 0;
  beat_t beat_q[$];
  resp_t resp_q[$];
  beat_t cur;
  bit    b_seen = 1'b0;
  int    b_cnt = 0;

  lsu_mem_master_if #(.ADDR_W(10)) bus ();
  lsu_mem_master_if #(.ADDR_W(10)) bus2 ();

  lsu_mem_master #(.ADDR_W(10), .SPLIT_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  lsu_mem_master #(.ADDR_W(10), .SPLIT_EN(1'b0)) dut_nosplit (
    .i_clk(clk), .i_rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [9:0] a, input logic we, input logic [7:0] s,
                           input logic [63:0] wd, input logic [63:0] rd);
    beat_t b;
    b.addr = a; b.we = we; b.strb = s; b.wdata = wd; b.rdata = rd;
    beat_q.push_back(b);
  endtask

  task automatic push_resp(input logic [63:0] rd, input logic err);
    resp_t r;
    r.rdata = rd; r.err = err;
    resp_q.push_back(r);
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [9:0] a, input logic [63:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  // Issue one request from a negedge, measure cycles to resp_valid, confirm ready the cycle after.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [9:0] a,
                        input logic [63:0] wd, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    drive_req(we, f3, a, wd);
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      n++;
      if (bus.resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("resp_seen", seen, 1);
    if (exp_lat >= 0) chk("latency", n, exp_lat);
    @(negedge clk);
    chk("ready_after_resp", bus.req_ready, 1);
  endtask

  // RAM model: each beat is checked on first sight and on every held cycle, acked after ack_delay cycles.
  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (rst || !bus.mem_req) begin
      b_seen = 1'b0;
    end else begin
      if (!b_seen) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        cur = (beat_q.size() != 0) ? beat_q.pop_front() : '0;
        b_seen = 1'b1;
        b_cnt = 0;
        nbeats++;
      end
      chk("mem_addr",  bus.mem_addr,  cur.addr);
      chk("mem_we",    bus.mem_we,    cur.we);
      chk("mem_wstrb", bus.mem_wstrb, cur.strb);
      chk("mem_wdata", bus.mem_wdata, cur.wdata);
      if (b_cnt == ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = cur.rdata;
      end
      b_cnt++;
    end
  end

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      resp_t r;
      chk("resp_expected", resp_q.size() != 0, 1);
      r = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
      chk("resp_rdata", bus.resp_rdata, r.rdata);
      chk("resp_err",   bus.resp_err,   r.err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int start;
    drive_req(1'b0, 3'b0, 10'h0, 64'h0);
    bus.req_valid  = 1'b0;
    bus.mem_rdata  = 64'h0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = 3'b0;
    bus2.req_addr  = 10'h0; bus2.req_wdata = 64'h0;
    bus2.mem_ack   = 1'b0; bus2.mem_rdata = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  bus.req_ready,  1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err",   bus.resp_err,   0);
    chk("rst_mem_req",    bus.mem_req,    0);
    chk("rst_mem_we",     bus.mem_we,     0);
    chk("rst_mem_addr",   bus.mem_addr,   0);
    chk("rst_mem_wstrb",  bus.mem_wstrb,  0);
    chk("rst_mem_wdata",  bus.mem_wdata,  0);
    rst = 1'b0;
    @(negedge clk);

    // sd aligned
    push_beat(10'h010, 1'b1, 8'hFF, 64'h1122334455667788, 64'h0);
    push_resp(64'h0, 1'b0);
    do_req(1'b1, 3'd3, 10'h010, 64'h1122334455667788, 3);

    // lb / lbu of a 0x80 byte
    push_beat(10'h010, 1'b0, 8'h00, 64'h0, 64'h00000000_80000000);
    push_resp(64'hFFFFFFFFFFFFFF80, 1'b0);
    do_req(1'b0, 3'd0, 10'h013, 64'h0, 3);
    push_beat(10'h010, 1'b0, 8'h00, 64'h0, 64'h00000000_80000000);
    push_resp(64'h0000000000000080, 1'b0);
    do_req(1'b0, 3'd4, 10'h013, 64'h0, 3);

    // lw negative, lhu
    push_beat(10'h000, 1'b0, 8'h00, 64'h0, 64'h80001234_5555AAAA);
    push_resp(64'hFFFFFFFF80001234, 1'b0);
    do_req(1'b0, 3'd2, 10'h004, 64'h0, 3);
    push_beat(10'h008, 1'b0, 8'h00, 64'h0, 64'h00000000_F00D0000);
    push_resp(64'h000000000000F00D, 1'b0);
    do_req(1'b0, 3'd5, 10'h00A, 64'h0, 3);

    // sw crossing a doubleword
    push_beat(10'h008, 1'b1, 8'hC0, 64'hCCDD0000_00000000, 64'h0);
    push_beat(10'h010, 1'b1, 8'h03, 64'h00000000_0000AABB, 64'h0);
    push_resp(64'h0, 1'b0);
    do_req(1'b1, 3'd2, 10'h00E, 64'hAABBCCDD, 5);

    // ld wrapping past the top of the RAM
    push_beat(10'h3F8, 1'b0, 8'h00, 64'h0, 64'h44332211_00000000);
    push_beat(10'h000, 1'b0, 8'h00, 64'h0, 64'h00000000_88776655);
    push_resp(64'h8877665544332211, 1'b0);
    do_req(1'b0, 3'd3, 10'h3FC, 64'h0, 5);

    // lh crossing, positive result
    push_beat(10'h000, 1'b0, 8'h00, 64'h0, 64'hFE000000_00000000);
    push_beat(10'h008, 1'b0, 8'h00, 64'h0, 64'h00000000_0000007F);
    push_resp(64'h0000000000007FFE, 1'b0);
    do_req(1'b0, 3'd1, 10'h007, 64'h0, 5);

    // illegal store / load funct3: no beat
    push_resp(64'h0, 1'b1);
    do_req(1'b1, 3'd4, 10'h020, 64'h1234, 1);
    push_resp(64'h0, 1'b1);
    do_req(1'b0, 3'd7, 10'h020, 64'h0, 1);

    // delayed ack: mem_* held for five cycles
    ack_delay = 4;
    push_beat(10'h000, 1'b1, 8'hF0, 64'hDEADBEEF_00000000, 64'h0);
    push_resp(64'h0, 1'b0);
    do_req(1'b1, 3'd2, 10'h004, 64'hDEADBEEF, 7);

    // SPLIT_EN=0 rejects a crossing lh
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = 3'd1;
    bus2.req_addr = 10'h007; bus2.req_wdata = 64'h0;
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 1'b0;
    chk("nosplit_resp_valid", bus2.resp_valid, 1);
    chk("nosplit_resp_err",   bus2.resp_err,   1);
    chk("nosplit_mem_req",    bus2.mem_req,    0);
    @(negedge clk);
    chk("nosplit_resp_drop",  bus2.resp_valid, 0);
    chk("nosplit_mem_req2",   bus2.mem_req,    0);

    // reset during BEAT1 with a slow RAM
    push_beat(10'h008, 1'b1, 8'hC0, 64'hCCDD0000_00000000, 64'h0);
    push_beat(10'h010, 1'b1, 8'h03, 64'h00000000_0000AABB, 64'h0);
    start = nbeats;
    drive_req(1'b1, 3'd2, 10'h00E, 64'hAABBCCDD);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (nbeats < start + 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_beat1", nbeats - start, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_mem_req",    bus.mem_req,    0);
    chk("midrst_resp_valid", bus.resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    chk("midrst_req_ready", bus.req_ready, 1);
    repeat (6) @(negedge clk);
    chk("midrst_idle_mem_req", bus.mem_req, 0);

    chk("beat_q_empty", beat_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
